// File: rtl/alu_seq_ctrl.sv
// Command/response sequencer in front of the single-pass ripple ALU.
// Multi-bit logical shifts are built by looping the ALU result back once per cycle.
module alu_seq_ctrl #(
    parameter int DATA_W  = 32,
    parameter int SHAMT_W = 5
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               cmd_valid_i,
    output logic               cmd_ready_o,
    input  logic [3:0]         cmd_op_i,
    input  logic [DATA_W-1:0]  cmd_a_i,
    input  logic [DATA_W-1:0]  cmd_b_i,
    input  logic               cmd_cin_i,
    input  logic [SHAMT_W-1:0] cmd_shamt_i,
    output logic [DATA_W-1:0]  alu_a_o,
    output logic [DATA_W-1:0]  alu_b_o,
    output logic               alu_cin_o,
    output logic [3:0]         alu_sel_o,
    input  logic [DATA_W-1:0]  alu_f_i,
    input  logic               alu_cout_i,
    output logic               rsp_valid_o,
    input  logic               rsp_ready_i,
    output logic [DATA_W-1:0]  rsp_f_o,
    output logic               rsp_cout_o,
    output logic               rsp_zero_o
);

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        SHIFT,
        RESP
    } state_t;

    state_t              r_state;
    logic [DATA_W-1:0]   r_a;
    logic [DATA_W-1:0]   r_b;
    logic                r_cin;
    logic [3:0]          r_op;
    logic [SHAMT_W-1:0]  r_cnt;
    logic [DATA_W-1:0]   r_f;
    logic                r_cout;
    logic                r_zero;
    logic                r_ready;
    logic                r_valid;

    logic                w_accept;
    logic                w_alu_zero;
    logic                w_cmd_a_zero;

    assign w_accept     = cmd_valid_i && r_ready;
    assign w_alu_zero   = (alu_f_i == '0);
    assign w_cmd_a_zero = (cmd_a_i == '0);

    // r_a doubles as the shift working register; it feeds alu_a_o directly.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state <= IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_cin   <= 1'b0;
            r_op    <= '0;
            r_cnt   <= '0;
            r_f     <= '0;
            r_cout  <= 1'b0;
            r_zero  <= 1'b0;
            r_ready <= 1'b0;
            r_valid <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    r_ready <= 1'b1;
                    if (w_accept) begin
                        r_a     <= cmd_a_i;
                        r_b     <= cmd_b_i;
                        r_cin   <= cmd_cin_i;
                        r_op    <= cmd_op_i;
                        r_ready <= 1'b0;
                        if (!cmd_op_i[3]) begin
                            r_state <= EXEC;
                        end else if (cmd_shamt_i != '0) begin
                            r_state <= SHIFT;
                            r_cnt   <= cmd_shamt_i;
                        end else begin
                            r_state <= RESP;
                            r_f     <= cmd_a_i;
                            r_cout  <= 1'b0;
                            r_zero  <= w_cmd_a_zero;
                            r_valid <= 1'b1;
                        end
                    end
                end
                EXEC: begin
                    r_f     <= alu_f_i;
                    r_cout  <= alu_cout_i;
                    r_zero  <= w_alu_zero;
                    r_state <= RESP;
                    r_valid <= 1'b1;
                end
                SHIFT: begin
                    r_a   <= alu_f_i;
                    r_cnt <= r_cnt - SHAMT_W'(1);
                    if (r_cnt == SHAMT_W'(1)) begin
                        r_f     <= alu_f_i;
                        r_cout  <= 1'b0;
                        r_zero  <= w_alu_zero;
                        r_state <= RESP;
                        r_valid <= 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_ready_i) begin
                        r_state <= IDLE;
                        r_valid <= 1'b0;
                        r_ready <= 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_valid <= 1'b0;
                    r_ready <= 1'b0;
                end
            endcase
        end
    end

    assign cmd_ready_o = r_ready;
    assign rsp_valid_o = r_valid;
    assign alu_a_o     = r_a;
    assign alu_b_o     = r_b;
    assign alu_cin_o   = r_cin;
    assign alu_sel_o   = r_op;
    assign rsp_f_o     = r_f;
    assign rsp_cout_o  = r_cout;
    assign rsp_zero_o  = r_zero;

endmodule
